fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RAT CPU, directly upstream of the decode/control-vector register.
- Owns the 10-bit PC and drives the synchronous program ROM.
- Presents each fetched instruction with its PC and a valid bit; the downstream nop input is driven as ~out_valid.
- Handles pipeline stall, branch redirect from EX, and interrupt entry to the interrupt vector; raises a one-cycle intr_taken pulse consumed by the control-vector register's interrupt input.

Parameters:
PC_W, 10, program counter / ROM address width
IR_W, 18, instruction width
RESET_PC, 10'h000, PC after reset
INTR_VEC, 10'h3FF, interrupt service entry address

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold fetch, outputs frozen
br_taken  in  1  EX resolved taken branch/call/ret: redirect and squash
br_target  in  PC_W  redirect address, sampled when br_taken=1
intr_req  in  1  external interrupt request, level
i_en  in  1  interrupt-enable flag from flag block
imem_addr  out  PC_W  ROM address; ROM returns data one cycle later
imem_data  in  IR_W  ROM read data for the previous cycle's imem_addr
out_IR  out  IR_W  instruction to decode (imem_data passthrough)
out_PC  out  PC_W  PC of out_IR
out_valid  out  1  out_IR/out_PC hold a real instruction
nop  out  1  ~out_valid, drives downstream nop
intr_taken  out  1  one-cycle pulse on interrupt accept
ret_PC  out  PC_W  return address saved at interrupt accept, held until next accept

Behaviour:
- Registers:
  - pc_q: next address to fetch.
  - fpc_q: address whose data is on imem_data this cycle.
  - state: S_BOOT, S_RUN or S_BUBBLE.
  - ret_PC.
- Address mux: imem_addr = stall ? fpc_q : pc_q. During a stall the held instruction is re-read, so on release imem_data still matches fpc_q.
- Outputs: out_IR = imem_data; out_PC = fpc_q; out_valid = (state==S_RUN). Latency from address issue to out_IR is 1 cycle.
- Reset, when rst=1 at the clock edge: pc_q<=RESET_PC, fpc_q<=RESET_PC, state<=S_BOOT, ret_PC<=0, intr_taken<=0. After reset, out_valid=0 and nop=1.
- Priority each cycle: rst > br_taken > interrupt > stall > advance.
- br_taken (stall ignored): pc_q<=br_target+1; fpc_q<=br_target; imem_addr this cycle = br_target (combinational override); state<=S_RUN; out_valid this cycle forced 0 (squash).
- Interrupt accept, when intr_req & i_en & state==S_RUN & ~stall & ~br_taken:
  - Registered outputs: intr_taken<=1 for one cycle; ret_PC<=fpc_q. The current out_IR is squashed (out_valid forced 0 this cycle) and re-executes after RETIE.
  - Redirect as for a branch to INTR_VEC: imem_addr=INTR_VEC, pc_q<=INTR_VEC+1, fpc_q<=INTR_VEC, state<=S_BUBBLE.
  - In S_BUBBLE, out_valid=0 and no interrupt is accepted; next cycle state<=S_RUN. This gives the downstream register's SP_DECR/SCR_WE push cycle a free slot.
  - i_en is expected to be cleared by the CPU. A second accept needs intr_req & i_en again.
- Stall: pc_q, fpc_q and state hold; out_IR/out_PC stable; out_valid unchanged; intr_taken=0.
- Advance (S_RUN or S_BOOT, no event): fpc_q<=pc_q; pc_q<=pc_q+1; S_BOOT->S_RUN.
- PC arithmetic is modulo 2^PC_W: 10'h3FF+1 = 10'h000. No overflow flag.
- Simultaneous br_taken and intr_req: branch wins and the interrupt stays pending (level). It is accepted on the first S_RUN cycle after the redirect.
- rst during S_BUBBLE or during a stall: reset wins, any pending intr_taken is cleared, ret_PC is cleared.
- Only the intr_taken pulse and ret_PC are registered outputs. out_valid and nop are decoded from state plus the same-cycle br_taken/interrupt squash.

Decomposition:
- Shared package rat_pipe_pkg:
  - typedef enum fetch_state_t {S_BOOT, S_RUN, S_BUBBLE};
  - constants RAT_PC_W=10, RAT_IR_W=18, RAT_INTR_VEC=10'h3FF, RAT_RESET_PC=10'h000. Decode and control-vector stages reuse these.
- One sub-module, pc_next_mux: a combinational next-PC/imem_addr select (rst/br/intr/stall/advance). Kept separate so the hazard unit's bench can reuse it.

Test Plan:
- rst for 2 cycles, then release with ROM[i]=i → out_valid=0 first cycle. Then out_PC=0,1,2,… with out_IR=ROM[out_PC] each cycle, and nop=~out_valid.
- Stall 3 cycles while out_PC=5 → out_PC=5 and out_IR=ROM[5] held all 3 cycles, imem_addr=5. Release → out_PC=6 next cycle, no skipped or duplicated PC.
- br_taken with br_target=10'h120 while out_PC=7 → out_valid=0 that cycle, next cycle out_PC=10'h120, then 10'h121.
- intr_req=1, i_en=1 at out_PC=9 → intr_taken=1 one cycle, ret_PC=9, two bubble cycles, then out_PC=10'h3FF. Next PC wraps to 10'h000.
- br_taken and intr_req on the same cycle with target 10'h040 → no intr_taken that cycle, out_PC=10'h040, then intr_taken with ret_PC=10'h040.
- intr_req=1 with i_en=0 for 10 cycles → intr_taken stays 0, sequential fetch uninterrupted. stall=1 with intr_req=1, i_en=1 → no accept until the stall drops.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared RAT pipeline constants and the fetch FSM state type.
// Decode and control-vector stages import this package as well.
package rat_pipe_pkg;

    localparam int RAT_PC_W = 10;
    localparam int RAT_IR_W = 18;
    localparam logic [RAT_PC_W-1:0] RAT_INTR_VEC = 10'h3FF;
    localparam logic [RAT_PC_W-1:0] RAT_RESET_PC = 10'h000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_BUBBLE
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch bus: program ROM port plus the instruction/interrupt bundle to decode.
interface fetch_stage_if
    import rat_pipe_pkg::*;
#(
    parameter int PC_W = RAT_PC_W,
    parameter int IR_W = RAT_IR_W
);
    logic [PC_W-1:0] imem_addr;
    logic [IR_W-1:0] imem_data;
    logic [IR_W-1:0] out_IR;
    logic [PC_W-1:0] out_PC;
    logic            out_valid;
    logic            nop;
    logic            intr_taken;
    logic [PC_W-1:0] ret_PC;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_IR,
        output out_PC,
        output out_valid,
        output nop,
        output intr_taken,
        output ret_PC
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_IR,
        input  out_PC,
        input  out_valid,
        input  nop,
        input  intr_taken,
        input  ret_PC
    );
endinterface

// File: rtl/fetch_stage_pc_next_mux.sv
// Next-PC / ROM address select: rst > branch > interrupt > stall/hold > advance.
module pc_next_mux
    import rat_pipe_pkg::*;
#(
    parameter int                PC_W     = RAT_PC_W,
    parameter logic [PC_W-1:0]   RESET_PC = RAT_RESET_PC,
    parameter logic [PC_W-1:0]   INTR_VEC = RAT_INTR_VEC
) (
    input  logic            rst,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            intr_accept,
    input  logic            stall,
    input  logic            hold,
    input  logic [PC_W-1:0] pc_q,
    input  logic [PC_W-1:0] fpc_q,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc_d,
    output logic [PC_W-1:0] fpc_d
);
    localparam logic [PC_W-1:0] ONE = 1;

    always_comb begin
        imem_addr = pc_q;
        pc_d      = pc_q + ONE;
        fpc_d     = pc_q;
        if (rst) begin
            imem_addr = RESET_PC;
            pc_d      = RESET_PC;
            fpc_d     = RESET_PC;
        end else if (br_taken) begin
            imem_addr = br_target;
            pc_d      = br_target + ONE;
            fpc_d     = br_target;
        end else if (intr_accept) begin
            imem_addr = INTR_VEC;
            pc_d      = INTR_VEC + ONE;
            fpc_d     = INTR_VEC;
        end else if (stall || hold) begin
            // re-read the presented address so ROM data still matches fpc_q afterwards
            imem_addr = fpc_q;
            pc_d      = pc_q;
            fpc_d     = fpc_q;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// RAT CPU instruction fetch: PC, ROM addressing, branch redirect, interrupt entry.
//   state    | meaning
//   S_BOOT   | first cycle after reset, ROM read of RESET_PC in flight
//   S_RUN    | out_IR/out_PC hold a real instruction
//   S_BUBBLE | slot after interrupt accept, ROM read of INTR_VEC in flight
module fetch_stage
    import rat_pipe_pkg::*;
#(
    parameter int              PC_W     = RAT_PC_W,
    parameter int              IR_W     = RAT_IR_W,
    parameter logic [PC_W-1:0] RESET_PC = RAT_RESET_PC,
    parameter logic [PC_W-1:0] INTR_VEC = RAT_INTR_VEC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            intr_req,
    input  logic            i_en,
    fetch_stage_if.master   bus
);
    fetch_state_t    state, state_d;
    logic [PC_W-1:0] pc_q, fpc_q, pc_d, fpc_d;
    logic [PC_W-1:0] ret_pc_q;
    logic            intr_taken_q;
    logic            intr_accept;
    logic            valid;

    pc_next_mux #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .INTR_VEC (INTR_VEC)
    ) u_pc_next_mux (
        .rst         (rst),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .intr_accept (intr_accept),
        .stall       (stall),
        .hold        (state == S_BUBBLE),
        .pc_q        (pc_q),
        .fpc_q       (fpc_q),
        .imem_addr   (bus.imem_addr),
        .pc_d        (pc_d),
        .fpc_d       (fpc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_BOOT;
            pc_q         <= RESET_PC;
            fpc_q        <= RESET_PC;
            intr_taken_q <= 1'b0;
            ret_pc_q     <= '0;
        end else begin
            state        <= state_d;
            pc_q         <= pc_d;
            fpc_q        <= fpc_d;
            intr_taken_q <= intr_accept;
            if (intr_accept) begin
                ret_pc_q <= fpc_q;
            end
        end
    end

    always_comb begin
        state_d     = state;
        intr_accept = intr_req && i_en && (state == S_RUN) && !stall && !br_taken && !rst;
        if (br_taken) begin
            state_d = S_RUN;
        end else if (intr_accept) begin
            state_d = S_BUBBLE;
        end else if (!stall) begin
            state_d = S_RUN;
        end
        // the instruction on the outputs is squashed by a redirect in the same cycle
        valid = (state == S_RUN) && !br_taken && !intr_accept;
    end

    assign bus.out_IR     = bus.imem_data;
    assign bus.out_PC     = fpc_q;
    assign bus.out_valid  = valid;
    assign bus.nop        = ~valid;
    assign bus.intr_taken = intr_taken_q;
    assign bus.ret_PC     = ret_pc_q;
endmodule
